ldpc_3gpp_dec_cnode_p_min_acc: RTL and testbench
================================================

// Module: ldpc_3gpp_dec_cnode_p_min_acc
//
// PURPOSE
//   Downstream of the check node 2-way min-search engine. Serially merges the partial
//   {min1, min2, min1_col, sign} beats of one check-node row, framed by isop/ieop,
//   into the row's final two minimums. Applies offset-min-sum correction to the result
//   and presents it to the check node update/write-back stage.
//
// PARAMETERS
//   pLLR_W    5  LLR width incl. sign; magnitudes are pLLR_W-1 bits
//   pNODE_W   8  column index width (min1_col)
//   pOFFSET   1  offset subtracted from min1/min2 at output, saturating at 0; 0 = bypass
//
// PORTS
//   iclk          in   1          clock
//   ireset        in   1          asynchronous reset, active high
//   iclkena       in   1          clock enable; low freezes all state incl. oval
//   ival          in   1          input beat valid
//   isop          in   1          first beat of a row (qualified by ival)
//   ieop          in   1          last beat of a row (qualified by ival)
//   ivn_min1      in   pLLR_W-1   partial min1 magnitude
//   ivn_min2      in   pLLR_W-1   partial min2 magnitude (ivn_min2 >= ivn_min1)
//   ivn_min1_col  in   pNODE_W    column of partial min1
//   ivn_sign      in   1          XOR of the signs covered by this beat
//   oval          out  1          row result valid, 1-cycle pulse
//   omin1         out  pLLR_W-1   offset-corrected min1
//   omin2         out  pLLR_W-1   offset-corrected min2
//   omin1_col     out  pNODE_W    column of min1 (offset does not touch it)
//   osign         out  1          XOR of all ivn_sign in the row
//   oerr          out  1          framing error pulse
//
// BEHAVIOUR
//   - Reset: FSM=IDLE, accumulator 0, oval=0, oerr=0, omin1/omin2/omin1_col/osign=0.
//     Reset mid-row discards the partial row; no oval follows.
//   - All state advances only when iclkena=1.
//   - FSM IDLE/ACC. IDLE: ival&isop loads acc <= beat; ->ACC, or stays IDLE if ieop
//     on the same beat (single-beat row). ACC: each ival beat merges into acc;
//     ival&ieop -> IDLE.
//   - Merge (acc={a,b,ca}, beat={c,d,cc}), strict compares:
//     c<a: min1=c, col=cc, min2=(d<a)?d:a; else min1=a, col=ca, min2=(c<b)?c:b.
//     Ties keep the accumulator, so the earliest column wins. sign_acc ^= ivn_sign.
//   - Latency: result is registered at +1 after the ival&ieop beat. The output stage
//     applies min-pOFFSET saturating at 0 and registers omin*/osign/omin1_col with
//     oval=1 at +2. Outputs hold until the next oval.
//   - Back-to-back rows: an ieop beat followed immediately by an isop beat is legal.
//     One oval is produced per row, with no bubble.
//   - Framing errors (oerr pulses at +1, no oval produced):
//     ival without isop while in IDLE -> beat dropped;
//     isop while in ACC -> partial row dropped, new row starts from this beat.
//   - ival=0 cycles inside a row are gaps; acc holds.
//
// TESTING
//   1. 4-beat row {3,5,c0},{2,7,c1},{6,6,c2},{2,4,c3}, pOFFSET=1
//      -> oval at +2 after ieop; omin1=1, omin2=1 (2-1), omin1_col=1 (tie keeps c1).
//   2. Single beat isop=ieop=1 {0,9,c5}, sign=1 -> omin1=0 (saturated), omin2=8,
//      col=5, osign=1.
//   3. Two rows back-to-back with no gap -> two oval pulses exactly 2 beats apart,
//      each with correct, independent results.
//   4. isop injected mid-row -> oerr pulse; the first row yields no oval; the second
//      row's result excludes first-row beats.
//   5. iclkena low for 3 cycles mid-row, then ival gaps -> result identical to the
//      unstalled run, with oval delayed by the stall length.
//   6. ireset asserted mid-row -> outputs 0 immediately; a following clean row is
//      correct.

Source files
------------

// File: rtl/ldpc_3gpp_dec_cnode_p_min_acc.sv
// Check-node partial min accumulator.
// Merges the framed {min1, min2, min1_col, sign} beats of one row into the row's
// two minimums. The result is registered one cycle after the last beat. A second
// register stage applies the offset-min-sum correction and drives oval.
module ldpc_3gpp_dec_cnode_p_min_acc #(
    parameter int pLLR_W  = 5,
    parameter int pNODE_W = 8,
    parameter int pOFFSET = 1
) (
    input  logic               iclk,
    input  logic               ireset,
    input  logic               iclkena,
    input  logic               ival,
    input  logic               isop,
    input  logic               ieop,
    input  logic [pLLR_W-2:0]  ivn_min1,
    input  logic [pLLR_W-2:0]  ivn_min2,
    input  logic [pNODE_W-1:0] ivn_min1_col,
    input  logic               ivn_sign,
    output logic               oval,
    output logic [pLLR_W-2:0]  omin1,
    output logic [pLLR_W-2:0]  omin2,
    output logic [pNODE_W-1:0] omin1_col,
    output logic               osign,
    output logic               oerr
);

    localparam int cMAG_W = pLLR_W - 1;
    localparam logic [cMAG_W-1:0] cOFF = cMAG_W'(pOFFSET);

    typedef enum logic {IDLE, ACC} state_t;

    typedef struct packed {
        logic [cMAG_W-1:0]  min1;
        logic [cMAG_W-1:0]  min2;
        logic [pNODE_W-1:0] col;
        logic               sign;
    } mins_t;

    state_t state;
    mins_t  acc;
    mins_t  beat;
    mins_t  mrg;
    mins_t  nxt;
    mins_t  res;
    logic   res_val;

    // Subtract the offset from a magnitude, clamping at zero.
    function automatic logic [cMAG_W-1:0] sat_off(input logic [cMAG_W-1:0] m);
        return (m > cOFF) ? (m - cOFF) : '0;
    endfunction

    // Merge the incoming beat into the accumulator. Strict compares make ties keep
    // the accumulator, so the earliest column wins. An isop beat restarts the row
    // from the beat alone, which also covers a framing restart while in ACC.
    always_comb begin
        beat = '{min1: ivn_min1, min2: ivn_min2, col: ivn_min1_col, sign: ivn_sign};
        mrg  = acc;
        if (ivn_min1 < acc.min1) begin
            mrg.min1 = ivn_min1;
            mrg.col  = ivn_min1_col;
            mrg.min2 = (ivn_min2 < acc.min1) ? ivn_min2 : acc.min1;
        end else begin
            mrg.min2 = (ivn_min1 < acc.min2) ? ivn_min1 : acc.min2;
        end
        mrg.sign = acc.sign ^ ivn_sign;
        nxt      = isop ? beat : mrg;
    end

    // Framing FSM, accumulator and first result register.
    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            state   <= IDLE;
            acc     <= '0;
            res     <= '0;
            res_val <= 1'b0;
            oerr    <= 1'b0;
        end else if (iclkena) begin
            res_val <= 1'b0;
            oerr    <= 1'b0;
            if (ival) begin
                if (state == IDLE && !isop) begin
                    // Stray beat outside a row: drop it.
                    oerr <= 1'b1;
                end else begin
                    // An isop while in ACC abandons the partial row.
                    if (state == ACC && isop)
                        oerr <= 1'b1;
                    if (ieop) begin
                        res     <= nxt;
                        res_val <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        acc   <= nxt;
                        state <= ACC;
                    end
                end
            end
        end
    end

    // Output stage: offset correction, outputs hold until the next row result.
    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            oval      <= 1'b0;
            omin1     <= '0;
            omin2     <= '0;
            omin1_col <= '0;
            osign     <= 1'b0;
        end else if (iclkena) begin
            oval <= res_val;
            if (res_val) begin
                omin1     <= sat_off(res.min1);
                omin2     <= sat_off(res.min2);
                omin1_col <= res.col;
                osign     <= res.sign;
            end
        end
    end

endmodule

// File: tb/tb_ldpc_3gpp_dec_cnode_p_min_acc.sv
// Directed bench for the check-node min accumulator. The driver pushes the
// hand-computed expected row results, including the cycle at which each should
// appear, into a queue. The monitor pops and compares on every fresh oval.
module tb_ldpc_3gpp_dec_cnode_p_min_acc;

    logic       iclk = 1'b0;
    logic       ireset;
    logic       iclkena;
    logic       ival, isop, ieop;
    logic [3:0] ivn_min1, ivn_min2;
    logic [7:0] ivn_min1_col;
    logic       ivn_sign;
    logic       oval;
    logic [3:0] omin1, omin2;
    logic [7:0] omin1_col;
    logic       osign, oerr;

    ldpc_3gpp_dec_cnode_p_min_acc #(.pLLR_W(5), .pNODE_W(8), .pOFFSET(1)) dut (
        .iclk(iclk), .ireset(ireset), .iclkena(iclkena),
        .ival(ival), .isop(isop), .ieop(ieop),
        .ivn_min1(ivn_min1), .ivn_min2(ivn_min2),
        .ivn_min1_col(ivn_min1_col), .ivn_sign(ivn_sign),
        .oval(oval), .omin1(omin1), .omin2(omin2),
        .omin1_col(omin1_col), .osign(osign), .oerr(oerr)
    );

    always #5 iclk = ~iclk;

    typedef struct {
        int m1;
        int m2;
        int col;
        int s;
        int cyc;
    } exp_t;

    exp_t q[$];
    int   tests   = 0;
    int   fails   = 0;
    int   cyc     = 0;
    int   err_seen = 0;
    int   err_exp  = 0;
    logic en_q    = 1'b0;

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Cycle count and whether the last edge was enabled (outputs just updated).
    always @(posedge iclk) begin
        cyc  <= cyc + 1;
        en_q <= iclkena;
    end

    // Monitor: compare each fresh row result against the scoreboard head.
    always @(negedge iclk) begin
        if (!ireset && en_q) begin
            if (oerr) err_seen++;
            if (oval) begin
                if (q.size() == 0) begin
                    check("unexpected_oval", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("omin1", int'(omin1), e.m1);
                    check("omin2", int'(omin2), e.m2);
                    check("omin1_col", int'(omin1_col), e.col);
                    check("osign", int'(osign), e.s);
                    check("oval_cycle", cyc, e.cyc);
                end
            end
        end
    end

    // Drive one cycle of inputs; an ieop beat pushes its expected result.
    task automatic beat(input logic v, input logic sop, input logic eop,
                        input int m1, input int m2, input int col, input logic s,
                        input int e1 = 0, input int e2 = 0, input int ecol = 0,
                        input int es = 0, input logic expect_out = 1'b0);
        @(negedge iclk);
        iclkena      = 1'b1;
        ival         = v;
        isop         = sop;
        ieop         = eop;
        ivn_min1     = 4'(m1);
        ivn_min2     = 4'(m2);
        ivn_min1_col = 8'(col);
        ivn_sign     = s;
        if (expect_out) begin
            exp_t e;
            e = '{m1: e1, m2: e2, col: ecol, s: es, cyc: cyc + 2};
            q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) beat(1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0);
    endtask

    initial begin
        ireset = 1'b1; iclkena = 1'b1;
        ival = 0; isop = 0; ieop = 0;
        ivn_min1 = 0; ivn_min2 = 0; ivn_min1_col = 0; ivn_sign = 0;
        repeat (3) @(negedge iclk);
        check("rst_oval", int'(oval), 0);
        check("rst_oerr", int'(oerr), 0);
        check("rst_omin1", int'(omin1), 0);
        check("rst_omin2", int'(omin2), 0);
        check("rst_col", int'(omin1_col), 0);
        check("rst_osign", int'(osign), 0);
        ireset = 1'b0;
        idle(2);

        // 1: 4-beat row, tie on min1=2 keeps column 1.
        beat(1, 1, 0, 3, 5, 0, 1);
        beat(1, 0, 0, 2, 7, 1, 0);
        beat(1, 0, 0, 6, 6, 2, 1);
        beat(1, 0, 1, 2, 4, 3, 1, 1, 1, 1, 1, 1'b1);
        idle(3);

        // 2: single-beat row, min1 saturates at 0.
        beat(1, 1, 1, 0, 9, 5, 1, 0, 8, 5, 1, 1'b1);
        idle(3);

        // Stray beat in IDLE: dropped with oerr.
        beat(1, 0, 0, 7, 7, 99, 1);
        err_exp++;
        idle(3);

        // 3: back-to-back rows, oval pulses two cycles apart.
        beat(1, 1, 0, 4, 6, 10, 0);
        beat(1, 0, 1, 1, 8, 11, 1, 0, 3, 11, 1, 1'b1);
        beat(1, 1, 0, 7, 9, 20, 1);
        beat(1, 0, 1, 5, 5, 21, 0, 4, 4, 21, 1, 1'b1);
        idle(3);

        // 4: isop mid-row restarts the row; the first row gives no oval.
        beat(1, 1, 0, 2, 3, 30, 1);
        beat(1, 0, 0, 1, 2, 31, 1);
        beat(1, 1, 0, 6, 8, 40, 1);
        err_exp++;
        beat(1, 0, 1, 9, 12, 41, 0, 5, 7, 40, 1, 1'b1);
        idle(3);

        // 5: three frozen cycles (with a junk beat on the bus), then gaps.
        beat(1, 1, 0, 8, 10, 50, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge iclk);
            iclkena = 1'b0; ival = 1; isop = 1; ieop = 1;
            ivn_min1 = 0; ivn_min2 = 0; ivn_min1_col = 8'd77; ivn_sign = 1;
        end
        idle(2);
        beat(1, 0, 0, 3, 4, 51, 0);
        beat(1, 0, 1, 9, 9, 52, 1, 2, 3, 51, 0, 1'b1);
        idle(3);

        // 6: reset mid-row clears outputs at once; partial row is discarded.
        beat(1, 1, 0, 1, 2, 60, 1);
        beat(1, 0, 0, 1, 3, 61, 0);
        @(negedge iclk);
        ival = 0;
        #2 ireset = 1'b1;
        #1;
        check("rst_mid_omin2", int'(omin2), 0);
        check("rst_mid_col", int'(omin1_col), 0);
        check("rst_mid_oval", int'(oval), 0);
        @(negedge iclk);
        ireset = 1'b0;
        beat(1, 0, 1, 0, 1, 62, 0);  // orphan tail after reset: error, no oval
        err_exp++;
        beat(1, 1, 1, 5, 7, 70, 1, 4, 6, 70, 1, 1'b1);
        idle(6);

        check("pending_results", q.size(), 0);
        check("oerr_count", err_seen, err_exp);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Hard bound on run time.
    initial begin
        #20000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1);
    end

endmodule
